// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with the load-use / branch-after-load stall unit.
// Resolves the destination register at capture and exposes FSM state for checkers.
module id_ex_stage_reg #(
  parameter int DATA_W      = 32,
  parameter int ALU_OP_W    = 4,
  parameter int BR_LD_STALL = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [4:0]          id_rs,
  input  logic [4:0]          id_rt,
  input  logic [4:0]          id_rd,
  input  logic [1:0]          id_reg_dst,
  input  logic                id_uses_rt,
  input  logic                id_is_branch,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_mem_to_reg,
  input  logic                id_alu_src,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic [DATA_W-1:0]   id_rdata1,
  input  logic [DATA_W-1:0]   id_rdata2,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic                ext_stall,
  input  logic                flush,
  output logic                ex_valid,
  output logic [4:0]          ex_rs,
  output logic [4:0]          ex_rt,
  output logic [4:0]          ex_rd,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_mem_to_reg,
  output logic                ex_alu_src,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [DATA_W-1:0]   ex_rdata1,
  output logic [DATA_W-1:0]   ex_rdata2,
  output logic [DATA_W-1:0]   ex_imm,
  output logic                id_stall,
  output logic                dbg_state,
  output logic [1:0]          dbg_cnt
);

  // Flow control: ID presents an instruction whenever id_valid is high; it is
  // accepted into EX on a clock edge only when id_stall is low and flush is low.
  // ext_stall is the downstream hold: nothing moves (flush still wins).

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [4:0]          rd;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic [DATA_W-1:0]   rdata1;
    logic [DATA_W-1:0]   rdata2;
    logic [DATA_W-1:0]   imm;
  } slot_t;

  localparam logic [1:0] BR_N = 2'(BR_LD_STALL);

  state_e     state_q;
  logic [1:0] cnt_q;
  slot_t      slot_q;
  slot_t      slot_d;

  logic [4:0] dest;
  logic       cap_reg_write;
  logic       ld_hit;
  logic       hazard_stall;
  logic       bubble;
  logic [1:0] stall_len;

  always_comb begin
    dest = 5'd0;
    case (id_reg_dst)
      2'b00:   dest = id_rt;
      2'b01:   dest = id_rd;
      2'b10:   dest = 5'd31;
      default: dest = 5'd0;
    endcase
  end

  // r0 is never a real destination, so it can never create a hazard.
  assign cap_reg_write = id_reg_write & id_valid & (dest != 5'd0);

  assign ld_hit = slot_q.valid & slot_q.mem_read & slot_q.reg_write & id_valid &
                  ((slot_q.rd == id_rs) | (id_uses_rt & (slot_q.rd == id_rt)));

  assign hazard_stall = (state_q == ST_IDLE) & ld_hit;
  assign bubble       = hazard_stall | (state_q == ST_STALL);
  assign id_stall     = ext_stall | bubble;
  assign stall_len    = id_is_branch ? BR_N : 2'd1;

  always_comb begin
    slot_d = slot_q;
    if (flush) begin
      slot_d = '0;
    end else if (ext_stall) begin
      slot_d = slot_q;
    end else if (bubble) begin
      slot_d = '0;
    end else begin
      slot_d.valid      = id_valid;
      slot_d.rs         = id_rs;
      slot_d.rt         = id_rt;
      slot_d.rd         = cap_reg_write ? dest : 5'd0;
      slot_d.reg_write  = cap_reg_write;
      slot_d.mem_read   = id_mem_read;
      slot_d.mem_write  = id_mem_write;
      slot_d.mem_to_reg = id_mem_to_reg;
      slot_d.alu_src    = id_alu_src;
      slot_d.alu_op     = id_alu_op;
      slot_d.rdata1     = id_rdata1;
      slot_d.rdata2     = id_rdata2;
      slot_d.imm        = id_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Hazards are only evaluated in IDLE; STALL just counts down the remaining bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
    end else if (flush) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
    end else if (!ext_stall) begin
      case (state_q)
        ST_IDLE: begin
          if (ld_hit && (stall_len > 2'd1)) begin
            state_q <= ST_STALL;
            cnt_q   <= stall_len - 2'd1;
          end
        end
        ST_STALL: begin
          if (cnt_q <= 2'd1) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 2'd0;
        end
      endcase
    end
  end

  assign ex_valid      = slot_q.valid;
  assign ex_rs         = slot_q.rs;
  assign ex_rt         = slot_q.rt;
  assign ex_rd         = slot_q.rd;
  assign ex_reg_write  = slot_q.reg_write;
  assign ex_mem_read   = slot_q.mem_read;
  assign ex_mem_write  = slot_q.mem_write;
  assign ex_mem_to_reg = slot_q.mem_to_reg;
  assign ex_alu_src    = slot_q.alu_src;
  assign ex_alu_op     = slot_q.alu_op;
  assign ex_rdata1     = slot_q.rdata1;
  assign ex_rdata2     = slot_q.rdata2;
  assign ex_imm        = slot_q.imm;
  assign dbg_state     = (state_q == ST_STALL);
  assign dbg_cnt       = cnt_q;

  a_rw_implies_dest: assert property (@(posedge clk) disable iff (!rst_n)
    slot_q.reg_write |-> (slot_q.valid && (slot_q.rd != 5'd0)));

endmodule
